// File: rtl/ni_injector.sv
// rtl/ni_injector.sv - local-port packet injector: segments command + payload into head/body/tail flits
// Flits hold on OL while full is high; S_L carries the XY route chosen at command accept.
module ni_injector #(
  parameter int Width       = 8,
  parameter int Select      = 3,
  parameter int Coord_width = 3,
  parameter int Len_width   = 4,
  parameter int MY_X        = 0,
  parameter int MY_Y        = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [Coord_width-1:0] cmd_dst_x,
  input  logic [Coord_width-1:0] cmd_dst_y,
  input  logic [Len_width-1:0]   cmd_len,
  input  logic                   data_valid,
  output logic                   data_ready,
  input  logic [Width-3:0]       data_in,
  input  logic                   full,
  output logic [Width-1:0]       OL,
  output logic [Select-1:0]      S_L,
  output logic                   flit_valid,
  output logic                   busy,
  output logic [15:0]            sent_count
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] HEAD    = 2'd1;
  localparam logic [1:0] PAYLOAD = 2'd2;

  localparam logic [1:0] T_BODY  = 2'b00;
  localparam logic [1:0] T_HEAD  = 2'b01;
  localparam logic [1:0] T_TAIL  = 2'b10;
  localparam logic [1:0] T_HT    = 2'b11;

  localparam logic [Coord_width-1:0] MY_XC = Coord_width'(MY_X);
  localparam logic [Coord_width-1:0] MY_YC = Coord_width'(MY_Y);

  logic [1:0]           state_q, state_d;
  logic [Width-1:0]     ol_q, ol_d;
  logic [Select-1:0]    sl_q, sl_d;
  logic                 fv_q, fv_d;
  logic [15:0]          cnt_q, cnt_d;
  logic [Len_width-1:0] len_q, len_d;
  logic [Len_width-1:0] rem_q, rem_d;
  logic [Select-1:0]    route;
  logic                 xfer;
  logic                 data_acc;

  assign xfer       = fv_q && !full;
  assign cmd_ready  = (state_q == IDLE) && !fv_q;
  assign data_ready = (state_q == PAYLOAD) && (rem_q != '0) && (!fv_q || !full);
  assign data_acc   = data_valid && data_ready;
  assign busy       = (state_q != IDLE);

  assign OL         = ol_q;
  assign S_L        = sl_q;
  assign flit_valid = fv_q;
  assign sent_count = cnt_q;

  // X is resolved before Y; equal coordinates route to the local port.
  always_comb begin
    route = Select'(0);
    if (cmd_dst_x > MY_XC)      route = Select'(2);
    else if (cmd_dst_x < MY_XC) route = Select'(3);
    else if (cmd_dst_y > MY_YC) route = Select'(1);
    else if (cmd_dst_y < MY_YC) route = Select'(4);
  end

  always_comb begin
    state_d = state_q;
    ol_d    = ol_q;
    sl_d    = sl_q;
    fv_d    = fv_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    rem_d   = rem_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          len_d   = cmd_len;
          sl_d    = route;
          ol_d    = {(cmd_len == '0) ? T_HT : T_HEAD, cmd_dst_x, cmd_dst_y};
          fv_d    = 1'b1;
          state_d = HEAD;
        end
      end
      HEAD: begin
        if (xfer) begin
          fv_d = 1'b0;
          if (len_q == '0) begin
            cnt_d   = cnt_q + 16'd1;
            state_d = IDLE;
          end else begin
            rem_d   = len_q;
            state_d = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        // A new word may load on the same edge the previous flit leaves.
        if (xfer && (ol_q[Width-1:Width-2] == T_TAIL)) begin
          fv_d    = 1'b0;
          cnt_d   = cnt_q + 16'd1;
          state_d = IDLE;
        end else if (data_acc) begin
          ol_d  = {(rem_q == Len_width'(1)) ? T_TAIL : T_BODY, data_in};
          fv_d  = 1'b1;
          rem_d = rem_q - Len_width'(1);
        end else if (xfer) begin
          fv_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ol_q    <= '0;
      sl_q    <= '0;
      fv_q    <= 1'b0;
      cnt_q   <= '0;
      len_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      ol_q    <= ol_d;
      sl_q    <= sl_d;
      fv_q    <= fv_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      rem_q   <= rem_d;
    end
  end

endmodule
